// File: rtl/led_pkg.sv
// led_pkg: mode encodings and per-mode scan period shared by the LED scanner.
package led_pkg;
    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_L2R    = 2'd1;
    localparam logic [1:0] MODE_R2L    = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;
    localparam logic [1:0] MODE_LAST   = 2'd3;
    function automatic int mode_period(input logic [1:0] mode, input int nled);
        return (mode == MODE_BOUNCE) ? 2 * nled - 2 : (mode == MODE_FILL) ? nled + 1 : nled;
    endfunction
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: pausable, clearable prescaler producing one step tick per
// 2^(BASE_BITS-speed) running cycles.
module led_tick_gen #(
    parameter int BASE_BITS = 23,
    parameter int SW        = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          paused_i,
    input  logic [SW-1:0] speed_i,
    output logic          tick_o
);
    localparam logic [BASE_BITS-1:0] ONES = '1;
    logic [BASE_BITS-1:0] cnt_q, cnt_d, mask;
    // Higher speed narrows the all-ones tap window, halving the interval per level.
    always_comb begin
        mask   = ONES >> speed_i;
        tick_o = !paused_i && ((cnt_q & mask) == mask);
        cnt_d  = clr_i ? '0 : paused_i ? cnt_q : cnt_q + BASE_BITS'(1);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/led_scan_engine.sv
// led_scan_engine: NLED scanner with four patterns, selectable speed and pause,
// driven by single-cycle button pulses.
module led_scan_engine
    import led_pkg::*;
#(
    parameter  int NLED         = 4,
    parameter  int BASE_BITS    = 23,
    parameter  int SPEED_LEVELS = 4,
    localparam int SW           = (SPEED_LEVELS > 1) ? $clog2(SPEED_LEVELS) : 1,
    localparam int PW           = $clog2(2 * NLED)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            MODE_STEP,
    input  logic            SPEED_STEP,
    input  logic            PAUSE_TGL,
    output logic [NLED-1:0] LED,
    output logic [1:0]      MODE,
    output logic [SW-1:0]   SPEED,
    output logic            PAUSED
);
    localparam logic [NLED-1:0] ONE  = NLED'(1);
    localparam logic [NLED-1:0] ALL  = '1;
    logic [1:0]    mode_q, mode_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [SW-1:0] speed_q, speed_d;
    logic          paused_q, paused_d;
    logic          tick, wrap;
    int            p;

    led_tick_gen #(.BASE_BITS(BASE_BITS), .SW(SW)) u_tick (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (MODE_STEP | SPEED_STEP),
        .paused_i(paused_q),
        .speed_i (speed_q),
        .tick_o  (tick)
    );

    // Tick uses the pre-toggle pause state; a mode change's pos clear beats the tick.
    always_comb begin
        wrap     = 32'(pos_q) == mode_period(mode_q, NLED) - 1;
        mode_d   = MODE_STEP ? ((mode_q == MODE_LAST) ? MODE_BOUNCE : mode_q + 2'd1) : mode_q;
        pos_d    = MODE_STEP ? '0 : !tick ? pos_q : wrap ? '0 : pos_q + PW'(1);
        speed_d  = SPEED_STEP ? ((speed_q == SW'(SPEED_LEVELS - 1)) ? '0 : speed_q + SW'(1)) : speed_q;
        paused_d = paused_q ^ PAUSE_TGL;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q   <= MODE_BOUNCE;
            pos_q    <= '0;
            speed_q  <= '0;
            paused_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            pos_q    <= pos_d;
            speed_q  <= speed_d;
            paused_q <= paused_d;
        end
    end

    always_comb begin
        p   = 32'(pos_q);
        LED = '0;
        case (mode_q)
            MODE_BOUNCE: LED = (p < NLED) ? ONE << p : (p <= 2 * NLED - 3) ? ONE << (2 * NLED - 2 - p) : '0;
            MODE_L2R:    LED = (p < NLED) ? ONE << (NLED - 1 - p) : '0;
            MODE_R2L:    LED = (p < NLED) ? ONE << p : '0;
            MODE_FILL:   LED = (p <= NLED) ? ~(ALL << p) : '0;
            default:     LED = '0;
        endcase
    end

    assign MODE   = mode_q;
    assign SPEED  = speed_q;
    assign PAUSED = paused_q;
endmodule

// File: tb/tb_led_scan_engine.sv
// tb_led_scan_engine: directed plus random pulse stimulus against a table-driven
// reference model of the scanner (NLED=4, BASE_BITS=4, SPEED_LEVELS=4).
module tb_led_scan_engine;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       MODE_STEP = 1'b0, SPEED_STEP = 1'b0, PAUSE_TGL = 1'b0;
    logic [3:0] LED;
    logic [1:0] MODE;
    logic [1:0] SPEED;
    logic       PAUSED;
    int n_cmp = 0, n_err = 0;

    led_scan_engine #(.NLED(4), .BASE_BITS(4), .SPEED_LEVELS(4)) dut (
        .CLK(CLK), .RST(RST), .MODE_STEP(MODE_STEP), .SPEED_STEP(SPEED_STEP),
        .PAUSE_TGL(PAUSE_TGL), .LED(LED), .MODE(MODE), .SPEED(SPEED), .PAUSED(PAUSED)
    );

    always #5 CLK = ~CLK;

    logic [3:0] pat [4][6] = '{
        '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010},
        '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000},
        '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000},
        '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000}
    };
    int plen [4] = '{6, 4, 4, 5};
    int m_mode = 0, m_pos = 0, m_speed = 0, m_paused = 0, m_ph = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_tick();
        int iv = 16 >> m_speed;
        return (m_paused == 0) && (m_ph % iv == iv - 1);
    endfunction

    task automatic model(input bit ms, input bit ss, input bit pt, input bit r);
        int np;
        if (r) begin
            m_mode = 0; m_pos = 0; m_speed = 0; m_paused = 0; m_ph = 0;
        end else begin
            np = m_tick() ? (m_pos + 1) % plen[m_mode] : m_pos;
            if (ms) begin m_mode = (m_mode + 1) % 4; np = 0; end
            m_ph = (ms || ss) ? 0 : (m_paused != 0) ? m_ph : (m_ph + 1) % 16;
            if (ss) m_speed = (m_speed + 1) % 4;
            if (pt) m_paused = (m_paused == 0) ? 1 : 0;
            m_pos = np;
        end
    endtask

    task automatic cyc(input bit ms, input bit ss, input bit pt, input bit r);
        MODE_STEP = ms; SPEED_STEP = ss; PAUSE_TGL = pt; RST = r;
        model(ms, ss, pt, r);
        @(posedge CLK); #1;
        MODE_STEP = 0; SPEED_STEP = 0; PAUSE_TGL = 0; RST = 0;
        check("led", 32'(LED), 32'(pat[m_mode][m_pos]));
        check("mode", 32'(MODE), 32'(m_mode));
        check("speed", 32'(SPEED), 32'(m_speed));
        check("paused", 32'(PAUSED), 32'(m_paused));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        int k;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("rst_led", 32'(LED), 32'h1);
        run(15);
        check("first_step_pending", 32'(LED), 32'h1);
        cyc(0, 0, 0, 0);
        check("first_step", 32'(LED), 32'h2);
        run(100);
        for (int i = 0; i < 3; i++) begin
            run(23);
            cyc(1, 0, 0, 0);
            run(70);
        end
        cyc(1, 0, 0, 0);
        check("mode_wrap", 32'(MODE), 32'h0);
        cyc(0, 1, 0, 0);
        run(30);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        run(20);
        cyc(0, 1, 0, 0);
        run(40);
        k = 0;
        while (k < 200 && LED !== 4'b0100) begin cyc(0, 0, 0, 0); k++; end
        check("find_0100", 32'(LED), 32'h4);
        cyc(0, 0, 1, 0);
        run(100);
        check("pause_hold", 32'(LED), 32'h4);
        check("pause_flag", 32'(PAUSED), 32'h1);
        cyc(0, 0, 1, 0);
        run(40);
        cyc(0, 0, 1, 0);
        run(5);
        cyc(1, 0, 0, 0);
        check("paused_mode_step", 32'(PAUSED), 32'h1);
        run(20);
        cyc(0, 0, 1, 0);
        run(10);
        k = 0;
        while (k < 40 && !m_tick()) begin cyc(0, 0, 0, 0); k++; end
        check("tick_found", 32'(m_tick()), 32'h1);
        cyc(1, 1, 0, 0);
        check("coincident_pos0", 32'(LED), 32'(pat[m_mode][0]));
        run(30);
        run(10);
        cyc(1, 0, 0, 1);
        check("rst_prio_led", 32'(LED), 32'h1);
        check("rst_prio_mode", 32'(MODE), 32'h0);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 24) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 499) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
